// File: rtl/shift_frame_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
package shift_frame_rx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  // The upstream shift register resets to zeros, so the line idles low and the start bit is high.
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  // Bit counter must reach SIZE after the last data bit.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/shift_frame_rx_if.sv
// Serial-in / word-out bundle of the frame receiver.
// slave: the receiver side; master: the driver/consumer side.
interface shift_frame_rx_if #(
  parameter int unsigned SIZE = 8
) ();

  logic            srl_in;
  logic            bit_en;
  logic [SIZE-1:0] data_out;
  logic            data_valid;
  logic            data_ready;
  logic            frame_err;
  logic            overrun;
  logic            busy;

  modport slave (
    input  srl_in,
    input  bit_en,
    input  data_ready,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output srl_in,
    output bit_en,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/shift_frame_rx_hold.sv
// One-word holding register with valid/ready output. A new word loads when the register is
// empty or being drained on the same edge; otherwise it is dropped and overrun pulses.
module shift_frame_rx_hold
  import shift_frame_rx_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] word_i,
  input  logic            ready_i,
  output logic [SIZE-1:0] data_o,
  output logic            valid_o,
  output logic            overrun_o
);

  logic [SIZE-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            drain;

  assign drain = valid_q & ready_i;

  // Load / drain / drop decision.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      if (!valid_q || drain) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/shift_frame_rx.sv
// Serial frame receiver: start bit (1), SIZE data bits LSB-first, optional even parity, stop (0).
// Optional feature macro: SHIFT_FRAME_RX_PARITY_EN adds the parity bit and PARITY state.
module shift_frame_rx
  import shift_frame_rx_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  shift_frame_rx_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(SIZE);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] shreg_q, shreg_d;
  logic            frame_err_q, busy_q;
  logic            stop_edge, frame_good;
`ifdef SHIFT_FRAME_RX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Next-state, counter and shift register; nothing moves on edges without bit_en.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    stop_edge  = 1'b0;
    frame_good = 1'b0;
`ifdef SHIFT_FRAME_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (bus.bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (bus.srl_in == START_LVL) begin
            state_d = StData;
            cnt_d   = '0;
          end
        end
        StData: begin
          shreg_d = {bus.srl_in, shreg_q[SIZE-1:1]};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(SIZE - 1)) begin
`ifdef SHIFT_FRAME_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
        StParity: begin
`ifdef SHIFT_FRAME_RX_PARITY_EN
          par_d = bus.srl_in;
`endif
          state_d = StStop;
        end
        StStop: begin
          stop_edge = 1'b1;
`ifdef SHIFT_FRAME_RX_PARITY_EN
          frame_good = (bus.srl_in == STOP_LVL) && !((^shreg_q) ^ par_q);
`else
          frame_good = (bus.srl_in == STOP_LVL);
`endif
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM, counter, shift register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= stop_edge & ~frame_good;
      busy_q      <= (state_d != StIdle);
    end
  end

`ifdef SHIFT_FRAME_RX_PARITY_EN
  // Captured parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  logic [SIZE-1:0] hold_data;
  logic            hold_valid, hold_overrun;

  shift_frame_rx_hold #(
    .SIZE (SIZE)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_i    (stop_edge & frame_good),
    .word_i    (shreg_q),
    .ready_i   (bus.data_ready),
    .data_o    (hold_data),
    .valid_o   (hold_valid),
    .overrun_o (hold_overrun)
  );

  assign bus.data_out   = hold_data;
  assign bus.data_valid = hold_valid;
  assign bus.overrun    = hold_overrun;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_shift_frame_rx.sv
// Scoreboard bench for shift_frame_rx: frames are built from words, expectations are pushed
// when the stop bit is driven, and a negedge monitor pops them as the DUT presents results.
module tb_shift_frame_rx;
  import shift_frame_rx_pkg::*;

  localparam int unsigned SIZE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_frame_rx_if #(.SIZE(SIZE)) bus ();

  shift_frame_rx #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0] exp_words[$];
  int              ferr_q[$];
  int              ovr_q[$];
  logic            m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, then update the transaction-level model at the edge.
  task automatic tick(input logic srl, input logic en, input logic rdy, input bit stop,
                      input bit good, input logic [SIZE-1:0] w, input int id);
    bus.srl_in     = srl;
    bus.bit_en     = en;
    bus.data_ready = rdy;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
    end else if (stop && en) begin
      if (!good) ferr_q.push_back(id);
      else if (!m_valid || rdy) begin
        exp_words.push_back(w);
        m_valid = 1'b1;
      end else ovr_q.push_back(id);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  function automatic logic rdy_for(input int mode, input bit stop_tick);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom % 2);
      default: return stop_tick ? 1'b1 : 1'b0;
    endcase
  endfunction

  // en_mode: 0 continuous, 1 toggling 1,0,1,0, 2 random gaps.
  // rdy_mode: 0 low, 1 high, 2 random, 3 high only on the stop edge.
  task automatic send_frame(input logic [SIZE-1:0] w, input bit bad_stop, input bit bad_par,
                            input int en_mode, input int rdy_mode, input int id);
    logic bits[$];
    bit   good;
    bits.push_back(START_LVL);
    for (int i = 0; i < SIZE; i++) bits.push_back(w[i]);
`ifdef SHIFT_FRAME_RX_PARITY_EN
    bits.push_back((^w) ^ bad_par);
    good = !bad_stop && !bad_par;
`else
    good = !bad_stop;
`endif
    bits.push_back(bad_stop ? ~STOP_LVL : STOP_LVL);
    for (int k = 0; k < bits.size(); k++) begin
      bit last;
      last = (k == bits.size() - 1);
      if (en_mode == 2) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++)
          tick(1'($urandom % 2), 1'b0, rdy_for(rdy_mode, 1'b0), 1'b0, 1'b0, '0, id);
      end
      tick(bits[k], 1'b1, rdy_for(rdy_mode, last), last, good, w, id);
      if (k == 0) check("busy_after_start", 32'(bus.busy), 32'd1);
      if (last) check("busy_after_stop", 32'(bus.busy), 32'd0);
      if (en_mode == 1 && !last)
        tick(1'($urandom % 2), 1'b0, rdy_for(rdy_mode, 1'b0), 1'b0, 1'b0, '0, id);
    end
  endtask

  task automatic idle(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++)
      tick(IDLE_LVL, 1'($urandom % 2), rdy_for(rdy_mode, 1'b0), 1'b0, 1'b0, '0, -1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && m_valid; i++) tick(IDLE_LVL, 1'b1, 1'b1, 1'b0, 1'b0, '0, -1);
    tick(IDLE_LVL, 1'b1, 1'b0, 1'b0, 1'b0, '0, -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(IDLE_LVL, 1'b1, 1'b0, 1'b0, 1'b0, '0, -1);
    rst = 1'b0;
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
  endtask

  // Monitor: compare presented outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      check("data_valid", 32'(bus.data_valid), 32'(m_valid));
      if (bus.frame_err) begin
        checks++;
        if (ferr_q.size() == 0) begin
          errors++;
          $display("FAIL frame_err_pulse: got 1, expected 0");
        end else void'(ferr_q.pop_front());
      end
      if (bus.overrun) begin
        checks++;
        if (ovr_q.size() == 0) begin
          errors++;
          $display("FAIL overrun_pulse: got 1, expected 0");
        end else void'(ovr_q.pop_front());
      end
      if (bus.data_valid && bus.data_ready) begin
        if (exp_words.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_accept: got %0h, expected no word", bus.data_out);
        end else begin
          logic [SIZE-1:0] e;
          e = exp_words.pop_front();
          check("data_out", 32'(bus.data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    bus.srl_in     = IDLE_LVL;
    bus.bit_en     = 1'b0;
    bus.data_ready = 1'b0;
    do_reset();
    idle(2, 1);

    // Basic frame with consumer always ready.
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1, 1);
    idle(3, 1);

    // Bad stop bit, then a good frame.
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1, 2);
    idle(1, 1);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1, 3);
    idle(2, 1);

    // Back-to-back with no consumer: second word dropped.
    drain();
    send_frame(8'h11, 1'b0, 1'b0, 0, 0, 4);
    send_frame(8'h22, 1'b0, 1'b0, 0, 0, 5);
    idle(2, 0);
    idle(2, 1);

    // Drain coinciding with the stop edge of the next word.
    drain();
    send_frame(8'h11, 1'b0, 1'b0, 0, 0, 6);
    send_frame(8'h22, 1'b0, 1'b0, 0, 3, 7);
    idle(2, 0);
    drain();

    // Toggling bit_en.
    send_frame(8'h5A, 1'b0, 1'b0, 1, 1, 8);
    idle(2, 1);

    // Reset on the fourth data bit.
    drain();
    tick(START_LVL, 1'b1, 1'b1, 1'b0, 1'b0, '0, 9);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 9);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 9);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 9);
    do_reset();
    idle(4, 1);
    send_frame(8'h5A, 1'b0, 1'b0, 0, 1, 10);
    idle(2, 1);

`ifdef SHIFT_FRAME_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0, 0, 1, 11);
    idle(2, 1);
    send_frame(8'h07, 1'b0, 1'b1, 0, 1, 12);
    idle(2, 1);
`endif

    // Randomized frames, gaps and handshakes.
    for (int n = 0; n < 40; n++) begin
      logic [SIZE-1:0] w;
      bit bad_par;
      w = SIZE'($urandom);
`ifdef SHIFT_FRAME_RX_PARITY_EN
      bad_par = ($urandom % 6) == 0;
`else
      bad_par = 1'b0;
`endif
      send_frame(w, ($urandom % 8) == 0, bad_par, $urandom_range(0, 2), $urandom_range(0, 3),
                 100 + n);
      idle($urandom_range(0, 3), 2);
    end

    drain();
    idle(3, 1);
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("frame_err_left", 32'(ferr_q.size()), 32'd0);
    check("overrun_left", 32'(ovr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
